// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
//   Shares one single-ported, multi-cycle main memory between the I-cache
//   miss fill, the D-cache miss fill and D-side write-through stores.
//   A block fill is issued as a pipelined burst of BLOCK_WORDS reads. The
//   returned words are counted and steered into the owning cache. A store
//   occupies one memory cycle. busy is high whenever the arbiter is not idle.
//
//   The read latency of the memory is not built into this block. Returns
//   are tracked only through mem_data_valid, and they come back in issue order.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   i_miss_req / i_miss_addr    I-cache miss (level, held until i_fill_done)
//   d_miss_req / d_miss_addr    D-cache miss (level, held until d_fill_done)
//   d_wr_req / d_wr_addr /
//   d_wr_data                   write-through store (level, held until d_wr_ack)
//   mem_addr, mem_enable,
//   mem_wr, mem_data_in         memory request side
//   mem_data_out,
//   mem_data_valid              memory read return side
//   fill_data, fill_word_idx    word and index written into a cache data array
//   i_fill_we, d_fill_we        write strobe into the owning cache
//   i_fill_done, d_fill_done    one-cycle pulse with the last word of a block
//   d_wr_ack                    one-cycle pulse when a store goes to memory
//   busy                        high in any state other than IDLE
module mem_fill_arbiter #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_miss_req,
   input  logic [ADDR_W-1:0]              i_miss_addr,
   input  logic                           d_miss_req,
   input  logic [ADDR_W-1:0]              d_miss_addr,
   input  logic                           d_wr_req,
   input  logic [ADDR_W-1:0]              d_wr_addr,
   input  logic [15:0]                    d_wr_data,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic                           mem_enable,
   output logic                           mem_wr,
   output logic [15:0]                    mem_data_in,
   input  logic [15:0]                    mem_data_out,
   input  logic                           mem_data_valid,
   output logic [15:0]                    fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
   output logic                           i_fill_we,
   output logic                           d_fill_we,
   output logic                           i_fill_done,
   output logic                           d_fill_done,
   output logic                           d_wr_ack,
   output logic                           busy
);

   localparam int IDX_W  = $clog2(BLOCK_WORDS);
   localparam int OFF_W  = IDX_W + 1;          // word index plus byte bit
   localparam int BASE_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

   // owner / last_served encoding: 0 = I side, 1 = D side
   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_served_q, last_served_d;
   logic [BASE_W-1:0]   base_q, base_d;
   logic [IDX_W:0]      issue_cnt_q, issue_cnt_d;   // extra MSB marks burst fully issued
   logic [IDX_W-1:0]    rcv_cnt_q, rcv_cnt_d;
   logic                pick_d;

   // Fills are block aligned; the word offset of a miss address is irrelevant.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_miss_addr[OFF_W-1:0], d_miss_addr[OFF_W-1:0]};

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_served_d = last_served_q;
      base_d        = base_q;
      issue_cnt_d   = issue_cnt_q;
      rcv_cnt_d     = rcv_cnt_q;
      pick_d        = 1'b0;
      mem_addr      = '0;
      mem_enable    = 1'b0;
      mem_wr        = 1'b0;
      mem_data_in   = '0;
      fill_data     = '0;
      fill_word_idx = '0;
      i_fill_we     = 1'b0;
      d_fill_we     = 1'b0;
      i_fill_done   = 1'b0;
      d_fill_done   = 1'b0;
      d_wr_ack      = 1'b0;

      case (state_q)
         IDLE: begin
            if (d_wr_req) begin
               state_d = WRITE;
            end else if (i_miss_req || d_miss_req) begin
               // With both misses pending, serve the side that went last time's opposite.
               pick_d      = (i_miss_req && d_miss_req) ? ~last_served_q : d_miss_req;
               owner_d     = pick_d;
               base_d      = pick_d ? d_miss_addr[ADDR_W-1:OFF_W] : i_miss_addr[ADDR_W-1:OFF_W];
               issue_cnt_d = '0;
               rcv_cnt_d   = '0;
               state_d     = FILL;
            end
         end

         WRITE: begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = d_wr_addr;
            mem_data_in = d_wr_data;
            d_wr_ack    = 1'b1;
            state_d     = IDLE;
         end

         FILL: begin
            if (!issue_cnt_q[IDX_W]) begin
               mem_enable  = 1'b1;
               mem_addr    = {base_q, issue_cnt_q[IDX_W-1:0], 1'b0};
               issue_cnt_d = issue_cnt_q + 1'b1;
            end
            if (mem_data_valid) begin
               fill_data     = mem_data_out;
               fill_word_idx = rcv_cnt_q;
               i_fill_we     = ~owner_q;
               d_fill_we     = owner_q;
               rcv_cnt_d     = rcv_cnt_q + 1'b1;
               if (&rcv_cnt_q) begin
                  i_fill_done   = ~owner_q;
                  d_fill_done   = owner_q;
                  last_served_d = owner_q;
                  state_d       = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         last_served_q <= 1'b0;
         base_q        <= '0;
         issue_cnt_q   <= '0;
         rcv_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_served_q <= last_served_d;
         base_q        <= base_d;
         issue_cnt_q   <= issue_cnt_d;
         rcv_cnt_q     <= rcv_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Testbench for mem_fill_arbiter: a 4-cycle-latency memory model, directed
// scenarios, randomized requesters, and a cycle-offset reference model.
module tb_mem_fill_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_miss_req, d_miss_req, d_wr_req;
   logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
   logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
   logic        mem_enable, mem_wr, mem_data_valid;
   logic [2:0]  fill_word_idx;
   logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

   always #5 clk = ~clk;

   mem_fill_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
      .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
      .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_data_valid(mem_data_valid),
      .fill_data(fill_data), .fill_word_idx(fill_word_idx),
      .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
      .d_wr_ack(d_wr_ack), .busy(busy)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- memory model: word array, 4-cycle read latency ----------------
   logic [15:0] mem [0:32767];
   logic        sched_v [0:7];
   logic [15:0] sched_d [0:7];
   bit          noise = 1'b0;   // random valid/data while reset is held
   bit          spur  = 1'b0;   // stray valid pulses while the arbiter is idle

   initial begin
      for (int a = 0; a < 32768; a++) mem[a] = 16'($urandom);
      for (int k = 0; k < 8; k++) mem[15'h0918 + k] = 16'(16'h00A0 + k);
      for (int s = 0; s < 8; s++) begin sched_v[s] = 1'b0; sched_d[s] = '0; end
      mem_data_valid = 1'b0;
      mem_data_out   = '0;
      forever begin
         @(negedge clk);
         sched_v[cyc % 8] = 1'b0;
         if (rst_n && mem_enable && !mem_wr) begin
            sched_v[(cyc + 4) % 8] = 1'b1;
            sched_d[(cyc + 4) % 8] = mem[mem_addr[15:1]];
         end
         if (rst_n && mem_enable && mem_wr) mem[mem_addr[15:1]] = mem_data_in;
         @(posedge clk);
         #1;
         if (noise) begin
            mem_data_valid = 1'($urandom);
            mem_data_out   = 16'($urandom);
         end else if (sched_v[cyc % 8]) begin
            mem_data_valid = 1'b1;
            mem_data_out   = sched_d[cyc % 8];
         end else begin
            mem_data_valid = spur && !busy && ($urandom_range(3) == 0);
            mem_data_out   = 16'($urandom);
         end
      end
   end

   // ---------------- reference model + per-cycle comparison ----------------
   // m_mode: 0 idle, 1 store, 2 block fill (m_k = cycles since the fill began)
   int          m_mode = 0, m_k = 0;
   bit          m_owner = 1'b0, m_last = 1'b0;
   logic [11:0] m_base = '0;
   int          i_done_cnt = 0, d_done_cnt = 0, ack_cnt = 0, i_we_cnt = 0, d_we_cnt = 0;
   int          i_done_cyc = 0, d_done_cyc = 0, ack_cyc = 0, issue0_cyc = 0;
   logic [15:0] issue0_addr = '0;
   logic [15:0] cap [0:7];

   initial begin : cmp
      logic        e_en, e_wr, e_iwe, e_dwe, e_idone, e_ddone, e_ack, e_busy;
      logic [15:0] e_addr, e_din, e_data;
      logic [2:0]  e_idx;
      int          idx;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("reset_ctrl", 32'({mem_enable, mem_wr, i_fill_we, d_fill_we,
                                   i_fill_done, d_fill_done, d_wr_ack, busy}), 32'd0);
            chk("reset_mem_addr", 32'(mem_addr), 32'd0);
            chk("reset_mem_data_in", 32'(mem_data_in), 32'd0);
            chk("reset_fill_data", 32'(fill_data), 32'd0);
            chk("reset_fill_idx", 32'(fill_word_idx), 32'd0);
            m_mode = 0;
            m_last = 1'b0;
         end else begin
            e_en = 0; e_wr = 0; e_iwe = 0; e_dwe = 0; e_idone = 0; e_ddone = 0;
            e_ack = 0; e_busy = 0; e_addr = '0; e_din = '0; e_data = '0; e_idx = '0;
            case (m_mode)
               0: begin
                  if (d_wr_req) m_mode = 1;
                  else if (i_miss_req || d_miss_req) begin
                     m_owner = (i_miss_req && d_miss_req) ? !m_last : d_miss_req;
                     m_base  = m_owner ? d_miss_addr[15:4] : i_miss_addr[15:4];
                     m_k     = 0;
                     m_mode  = 2;
                  end
               end
               1: begin
                  e_en = 1; e_wr = 1; e_addr = d_wr_addr; e_din = d_wr_data;
                  e_ack = 1; e_busy = 1;
                  m_mode = 0;
               end
               default: begin
                  e_busy = 1;
                  if (m_k < 8) begin e_en = 1; e_addr = {m_base, 3'(m_k), 1'b0}; end
                  if (m_k >= 4 && m_k <= 11) begin
                     idx    = m_k - 4;
                     e_iwe  = !m_owner;
                     e_dwe  = m_owner;
                     e_idx  = 3'(idx);
                     e_data = mem[{m_base, 3'(idx)}];
                  end
                  if (m_k == 11) begin
                     e_idone = !m_owner;
                     e_ddone = m_owner;
                     m_last  = m_owner;
                     m_mode  = 0;
                  end else m_k++;
               end
            endcase

            chk("mem_enable", 32'(mem_enable), 32'(e_en));
            if (e_en) begin
               chk("mem_wr", 32'(mem_wr), 32'(e_wr));
               chk("mem_addr", 32'(mem_addr), 32'(e_addr));
               if (e_wr) chk("mem_data_in", 32'(mem_data_in), 32'(e_din));
            end
            chk("i_fill_we", 32'(i_fill_we), 32'(e_iwe));
            chk("d_fill_we", 32'(d_fill_we), 32'(e_dwe));
            if (e_iwe || e_dwe) begin
               chk("fill_data", 32'(fill_data), 32'(e_data));
               chk("fill_word_idx", 32'(fill_word_idx), 32'(e_idx));
            end
            chk("i_fill_done", 32'(i_fill_done), 32'(e_idone));
            chk("d_fill_done", 32'(d_fill_done), 32'(e_ddone));
            chk("d_wr_ack", 32'(d_wr_ack), 32'(e_ack));
            chk("busy", 32'(busy), 32'(e_busy));

            // observed events, used by the directed scenarios
            if (i_fill_done) begin i_done_cnt++; i_done_cyc = cyc; end
            if (d_fill_done) begin d_done_cnt++; d_done_cyc = cyc; end
            if (d_wr_ack) begin ack_cnt++; ack_cyc = cyc; end
            if (i_fill_we) begin i_we_cnt++; cap[fill_word_idx] = fill_data; end
            if (d_fill_we) d_we_cnt++;
            if (mem_enable && !mem_wr && mem_addr[3:1] == 3'd0) begin
               issue0_cyc  = cyc;
               issue0_addr = mem_addr;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   function automatic int evcnt(input int sel);
      case (sel)
         0: return i_done_cnt;
         1: return d_done_cnt;
         2: return ack_cnt;
         default: return i_we_cnt;
      endcase
   endfunction

   task automatic wait_ev(input int sel, input int target, input string name);
      int b;
      b = 0;
      while (evcnt(sel) < target && b < 60) begin step(1); b++; end
      if (evcnt(sel) < target) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s timeout: count %0d, required %0d", name, evcnt(sel), target);
      end
   endtask

   initial begin
      $display("watchdog armed");
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ti, td, ta, tw, w0, pi, pd, pa;
      rst_n = 1'b0; i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
      i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;

      // reset held while the memory side toggles valid
      noise = 1'b1;
      step(6);
      noise = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(2);

      // single I fill of block 0x1230
      ti = i_done_cnt + 1; w0 = d_we_cnt; tw = i_we_cnt;
      i_miss_addr = 16'h1236; i_miss_req = 1'b1;
      wait_ev(0, ti, "ifill_done");
      i_miss_req = 1'b0;
      chk("ifill_first_addr", 32'(issue0_addr), 32'h1230);
      for (int k = 0; k < 8; k++) chk("ifill_word", 32'(cap[k]), 32'(8'hA0 + k));
      chk("ifill_done_latency", 32'(i_done_cyc - issue0_cyc), 32'd11);
      chk("ifill_no_dwe", 32'(d_we_cnt - w0), 32'd0);
      chk("ifill_we_count", 32'(i_we_cnt - tw), 32'd8);
      step(2);

      // simultaneous misses right after reset: D first, then I
      ti = i_done_cnt + 1; td = d_done_cnt + 1;
      i_miss_addr = 16'h2008; d_miss_addr = 16'h300C;
      i_miss_req = 1'b1; d_miss_req = 1'b1;
      wait_ev(1, td, "pair1_d_done");
      d_miss_req = 1'b0;
      wait_ev(0, ti, "pair1_i_done");
      i_miss_req = 1'b0;
      chk("pair1_d_first", 32'(d_done_cyc < i_done_cyc), 32'd1);
      chk("pair1_i_start_gap", 32'(issue0_cyc - d_done_cyc), 32'd2);
      chk("pair1_i_addr", 32'(issue0_addr), 32'h2000);
      step(2);

      // store and D miss together: store first, then the D fill
      ta = ack_cnt + 1; td = d_done_cnt + 1;
      d_wr_addr = 16'h0100; d_wr_data = 16'h1234; d_miss_addr = 16'h4000;
      d_wr_req = 1'b1; d_miss_req = 1'b1;
      wait_ev(2, ta, "sbm_ack");
      d_wr_req = 1'b0;
      wait_ev(1, td, "sbm_d_done");
      d_miss_req = 1'b0;
      chk("sbm_fill_gap", 32'(issue0_cyc - ack_cyc), 32'd2);
      chk("sbm_mem_written", 32'(mem[15'h0080]), 32'h1234);
      chk("sbm_d_addr", 32'(issue0_addr), 32'h4000);
      step(2);

      // second simultaneous pair, last served was D: I first
      ti = i_done_cnt + 1; td = d_done_cnt + 1;
      i_miss_addr = 16'h2100; d_miss_addr = 16'h3100;
      i_miss_req = 1'b1; d_miss_req = 1'b1;
      wait_ev(0, ti, "pair2_i_done");
      i_miss_req = 1'b0;
      wait_ev(1, td, "pair2_d_done");
      d_miss_req = 1'b0;
      chk("pair2_i_first", 32'(i_done_cyc < d_done_cyc), 32'd1);
      step(2);

      // store arriving in the third cycle of an I fill waits for the fill
      ti = i_done_cnt + 1; ta = ack_cnt + 1;
      i_miss_addr = 16'h5004; i_miss_req = 1'b1;
      step(3);
      d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
      i_miss_addr = 16'hFFFF;
      wait_ev(0, ti, "sdf_i_done");
      i_miss_req = 1'b0;
      wait_ev(2, ta, "sdf_ack");
      d_wr_req = 1'b0;
      chk("sdf_ack_gap", 32'(ack_cyc - i_done_cyc), 32'd2);
      chk("sdf_mem_written", 32'(mem[15'h0020]), 32'hBEEF);
      chk("sdf_i_addr", 32'(issue0_addr), 32'h5000);
      step(2);

      // reset after three returned words; stale returns must be dropped
      ti = i_done_cnt; tw = i_we_cnt + 3;
      i_miss_addr = 16'h6000; i_miss_req = 1'b1;
      wait_ev(3, tw, "rmf_words");
      rst_n = 1'b0; i_miss_req = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(6);
      chk("rmf_no_done", 32'(i_done_cnt), 32'(ti));
      chk("rmf_no_stale_we", 32'(i_we_cnt), 32'(tw));
      ti = i_done_cnt + 1;
      i_miss_req = 1'b1;
      wait_ev(0, ti, "rmf_refill_done");
      i_miss_req = 1'b0;
      chk("rmf_refill_addr", 32'(issue0_addr), 32'h6000);
      for (int k = 0; k < 8; k++) chk("rmf_refill_word", 32'(cap[k]), 32'(mem[15'h3000 + k]));
      step(2);

      // randomized requesters; each holds its request until its done/ack
      spur = 1'b1;
      pi = i_done_cnt; pd = d_done_cnt; pa = ack_cnt;
      for (int c = 0; c < 2500; c++) begin
         if (i_done_cnt != pi) begin i_miss_req = 1'b0; pi = i_done_cnt; end
         else if (!i_miss_req && $urandom_range(7) == 0) begin
            i_miss_addr = 16'($urandom); i_miss_req = 1'b1;
         end
         if (d_done_cnt != pd) begin d_miss_req = 1'b0; pd = d_done_cnt; end
         else if (!d_miss_req && $urandom_range(7) == 0) begin
            d_miss_addr = 16'($urandom); d_miss_req = 1'b1;
         end
         if (ack_cnt != pa) begin d_wr_req = 1'b0; pa = ack_cnt; end
         else if (!d_wr_req && $urandom_range(9) == 0) begin
            d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom); d_wr_req = 1'b1;
         end
         step(1);
      end
      for (int c = 0; c < 100; c++) begin
         if (i_done_cnt != pi) begin i_miss_req = 1'b0; pi = i_done_cnt; end
         if (d_done_cnt != pd) begin d_miss_req = 1'b0; pd = d_done_cnt; end
         if (ack_cnt != pa) begin d_wr_req = 1'b0; pa = ack_cnt; end
         step(1);
      end
      chk("drain_all_served", 32'({i_miss_req, d_miss_req, d_wr_req}), 32'd0);
      spur = 1'b0;
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
Shares the single-ported, multi-cycle main memory among three requesters: I-cache miss fill, D-cache miss fill, and D-side write-through stores. It sequences each 8-word block fill as a pipelined burst of reads, counts the returned words and steers them into the requesting cache. It also raises busy so the CPU pipeline can stall. It sits between the I/D caches and the unified memory model, below the cpu top level.

Parameters:
MEM_LATENCY, 4, cycles from a read issue (mem_enable=1, mem_wr=0) to mem_data_valid for that word
BLOCK_WORDS, 8, 16-bit words per cache block; fixed power of two, index width = log2(BLOCK_WORDS)
ADDR_W, 16, byte-address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_miss_req  input  1  I-cache miss pending; level, held until i_fill_done
i_miss_addr  input  16  missing I address (byte address)
d_miss_req  input  1  D-cache miss pending; level, held until d_fill_done
d_miss_addr  input  16  missing D address
d_wr_req  input  1  write-through store pending; level, held until d_wr_ack
d_wr_addr  input  16  store address
d_wr_data  input  16  store data
mem_addr  output  16  memory address
mem_enable  output  1  memory access strobe
mem_wr  output  1  1 = write, 0 = read
mem_data_in  output  16  write data to memory
mem_data_out  input  16  read data from memory
mem_data_valid  input  1  read data valid
fill_data  output  16  word to write into the cache data array
fill_word_idx  output  3  word index within the block
i_fill_we  output  1  write fill_data into the I-cache
d_fill_we  output  1  write fill_data into the D-cache
i_fill_done  output  1  one-cycle pulse; I block complete, tag may be validated
d_fill_done  output  1  one-cycle pulse; D block complete
d_wr_ack  output  1  one-cycle pulse; store accepted by memory
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE and all counters = 0. Every output is 0, including mem_addr, fill_data and fill_word_idx. last_served is set to I.
- States: IDLE, WRITE, FILL. The FILL state carries a registered owner bit (I or D).
- IDLE arbitration, evaluated each cycle, highest first:
  - d_wr_req -> WRITE.
  - Both misses pending -> FILL, owner = the requester opposite last_served (round robin).
  - Only one miss pending -> FILL, owner = that requester.
  - base = miss_addr[15:4] is latched on the transition; IDLE drives no memory access.
- WRITE (exactly 1 cycle): mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_ack=1. Next state is IDLE.
- FILL issue phase:
  - issue_cnt runs 0..7, starting on the first FILL cycle.
  - Each cycle: mem_enable=1, mem_wr=0, mem_addr={base, issue_cnt[2:0], 1'b0}, issue_cnt++.
  - After issue_cnt reaches 8, mem_enable=0 for the rest of FILL.
- FILL return phase:
  - On each mem_data_valid: fill_data=mem_data_out, fill_word_idx=rcv_cnt, and the owner's fill_we=1 (combinational, same cycle). Then rcv_cnt++.
  - Returns are in issue order.
- Completion: the cycle rcv_cnt==7 receives valid is the last one. The owner's fill_done pulses in that same cycle, alongside the last fill_we. last_served<=owner, and the next state is IDLE.
- Latency: FILL entered at cycle T gives reads at T..T+7, data at T+L..T+7+L, and done at T+7+L. IDLE at T+8+L. With L=4, a fill occupies 12 cycles plus 1 IDLE arbitration cycle.
- A miss request dropped mid-FILL is ignored; the fill runs to completion and done still pulses.
- A d_wr_req arriving during FILL waits (busy=1) and is served on the first arbitration after the fill. Writes never interleave with a burst.
- mem_data_valid in IDLE or WRITE is ignored; no fill_we is produced. This covers stale returns after a mid-burst reset.
- Reset mid-FILL: the block is abandoned and no done pulses. The requester re-requests after reset.
- Requester address inputs are not sampled after the transition into FILL.
- Word-offset bits [3:0] of the miss address are ignored; fills are block-aligned.

Test Plan:
- Reset: hold rst_n=0 with mem_data_valid toggling -> all outputs 0, busy=0, no fill_we.
- I fill: i_miss_req=1, addr=0x1236 -> reads issued to 0x1230,0x1232,...,0x123E on 8 consecutive cycles. Returned data 0xA0..0xA7 appears on i_fill_we with idx 0..7. i_fill_done coincides with idx 7, 11 cycles after the first issue. d_fill_we stays 0 throughout.
- Simultaneous misses: i_miss_req and d_miss_req rise together after reset -> D is served first (last_served=I). I follows, starting 1 IDLE cycle after d_fill_done. On a second simultaneous pair, I goes first.
- Store during fill: d_wr_req (addr 0x0040, data 0xBEEF) raised in the third cycle of an I fill -> no write until the fill completes. Then one WRITE cycle with mem_wr=1, addr 0x0040, data 0xBEEF, and d_wr_ack pulses.
- Store beats miss: d_wr_req and d_miss_req rise together -> WRITE, then FILL(D) in the next arbitration.
- Reset mid-fill: assert rst_n=0 after 3 returned words, then release. Remaining valid pulses must produce no fill_we or done. A fresh i_miss_req then fills normally from word 0.
